// File: rtl/pcs_synchronization_pkg.sv
// Shared types and constants for the 1000BASE-X PCS receive synchronization block.
package pcs_synchronization_pkg;

    typedef enum logic [3:0] {
        LOSS_OF_SYNC     = 4'd0,
        COMMA_DETECT_1   = 4'd1,
        COMMA_DETECT_2   = 4'd2,
        COMMA_DETECT_3   = 4'd3,
        ACQUIRE_SYNC_1   = 4'd4,
        ACQUIRE_SYNC_2   = 4'd5,
        SYNC_ACQUIRED_1  = 4'd6,
        SYNC_ACQUIRED_2  = 4'd7,
        SYNC_ACQUIRED_2A = 4'd8,
        SYNC_ACQUIRED_3  = 4'd9,
        SYNC_ACQUIRED_3A = 4'd10,
        SYNC_ACQUIRED_4  = 4'd11,
        SYNC_ACQUIRED_4A = 4'd12
    } sync_state_e;

    localparam logic [9:0] K28_5_NEG = 10'b0011111010;
    localparam logic [9:0] K28_5_POS = 10'b1100000101;
    localparam logic [9:0] D0_0_NEG  = 10'b1001110100;

    function automatic logic is_sync_acquired(input sync_state_e s);
        logic r;
        case (s)
            SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
            SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A,
            SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? 2'd3 : v + 2'd1;
    endfunction

endpackage

// File: rtl/pcs_synchronization_cg_classify.sv
// Combinational 8B/10B code-group classifier: invalid / comma / data.
// Running disparity is not tracked, so a sub-block is legal if it is legal for either disparity.
module pcs_cg_classify
    import pcs_synchronization_pkg::*;
(
    input  logic [9:0] code_group,
    output logic       invalid,
    output logic       comma,
    output logic       is_d
);

    logic [5:0] six_s;
    logic [3:0] four_s;
    logic       k28_s;
    logic       kx7_s;

    function automatic logic legal_6b(input logic [5:0] s);
        logic r;
        case (s)
            6'b100111, 6'b011000, 6'b011101, 6'b100010, 6'b101101, 6'b010010,
            6'b110001, 6'b110101, 6'b001010, 6'b101001, 6'b011001, 6'b111000,
            6'b000111, 6'b111001, 6'b000110, 6'b100101, 6'b010101, 6'b110100,
            6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b101000, 6'b011011,
            6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010,
            6'b011010, 6'b111010, 6'b000101, 6'b110011, 6'b001100, 6'b100110,
            6'b010110, 6'b110110, 6'b001001, 6'b001110, 6'b101110, 6'b010001,
            6'b011110, 6'b100001, 6'b101011, 6'b010100, 6'b001111, 6'b110000:
                r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic legal_4b(input logic [3:0] s);
        logic r;
        case (s)
            4'b1011, 4'b0100, 4'b1001, 4'b0101, 4'b1100, 4'b0011, 4'b1101,
            4'b0010, 4'b1010, 4'b0110, 4'b1110, 4'b0001, 4'b0111, 4'b1000:
                r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // 6b halves that K23.7/K27.7/K29.7/K30.7 share with data, which are K only when followed by an alternate-7 4b block
    function automatic logic kx7_6b(input logic [5:0] s);
        logic r;
        case (s)
            6'b111010, 6'b000101, 6'b110110, 6'b001001,
            6'b101110, 6'b010001, 6'b011110, 6'b100001: r = 1'b1;
            default:                                    r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        six_s   = code_group[9:4];
        four_s  = code_group[3:0];
        invalid = !(legal_6b(six_s) && legal_4b(four_s));
        comma   = (code_group[9:3] == 7'b0011111) || (code_group[9:3] == 7'b1100000);
        k28_s   = (six_s == 6'b001111) || (six_s == 6'b110000);
        kx7_s   = kx7_6b(six_s) && ((four_s == 4'b1000) || (four_s == 4'b0111));
        is_d    = !invalid && !k28_s && !kx7_s;
    end

endmodule

// File: rtl/pcs_synchronization.sv
// 1000BASE-X PCS receive synchronization: comma alignment, sync acquire/loss FSM,
// and the one-cycle SUDI / rx_even output stage.
module pcs_synchronization
    import pcs_synchronization_pkg::*;
(
    input  logic       clk,
    input  logic       mr_main_reset,
    input  logic       mr_loopback,
    input  logic       signal_detect,
    input  logic [9:0] code_group,
    output logic [9:0] SUDI,
    output logic       code_sync_status,
    output logic       rx_even
);

    sync_state_e state_q, state_d;
    logic [9:0]  sudi_q, sudi_d;
    logic        status_q, status_d;
    logic        rx_even_q, rx_even_d;
    logic [1:0]  good_cgs_q, good_cgs_d;
    logic        sd_prev_q, sd_prev_d;
    logic        sd_hist_vld_q, sd_hist_vld_d;

    logic        invalid_s, comma_s, is_d_s;
    logic        cgbad_s, sd_change_s;

    pcs_cg_classify u_classify (
        .code_group (code_group),
        .invalid    (invalid_s),
        .comma      (comma_s),
        .is_d       (is_d_s)
    );

    // History is treated as equal to signal_detect until the first post-reset edge, which avoids an async data load.
    always_comb begin
        cgbad_s       = invalid_s || (comma_s && rx_even_q);
        sd_change_s   = sd_hist_vld_q && (signal_detect != sd_prev_q);
        sd_prev_d     = signal_detect;
        sd_hist_vld_d = 1'b1;
        sudi_d        = code_group;
    end

    // Next-state selection; loss of signal overrides every state rule.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOSS_OF_SYNC:     state_d = (comma_s && (signal_detect || mr_loopback)) ? COMMA_DETECT_1 : LOSS_OF_SYNC;
            COMMA_DETECT_1:   state_d = is_d_s ? ACQUIRE_SYNC_1  : LOSS_OF_SYNC;
            COMMA_DETECT_2:   state_d = is_d_s ? ACQUIRE_SYNC_2  : LOSS_OF_SYNC;
            COMMA_DETECT_3:   state_d = is_d_s ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
            ACQUIRE_SYNC_1:   state_d = cgbad_s ? LOSS_OF_SYNC :
                                        (comma_s && !rx_even_q) ? COMMA_DETECT_2 : ACQUIRE_SYNC_1;
            ACQUIRE_SYNC_2:   state_d = cgbad_s ? LOSS_OF_SYNC :
                                        (comma_s && !rx_even_q) ? COMMA_DETECT_3 : ACQUIRE_SYNC_2;
            SYNC_ACQUIRED_1:  state_d = cgbad_s ? SYNC_ACQUIRED_2 : SYNC_ACQUIRED_1;
            SYNC_ACQUIRED_2:  state_d = cgbad_s ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_2A;
            SYNC_ACQUIRED_2A: state_d = cgbad_s ? SYNC_ACQUIRED_3 :
                                        (good_cgs_q == 2'd3) ? SYNC_ACQUIRED_1 : SYNC_ACQUIRED_2A;
            SYNC_ACQUIRED_3:  state_d = cgbad_s ? SYNC_ACQUIRED_4 : SYNC_ACQUIRED_3A;
            SYNC_ACQUIRED_3A: state_d = cgbad_s ? SYNC_ACQUIRED_4 :
                                        (good_cgs_q == 2'd3) ? SYNC_ACQUIRED_2 : SYNC_ACQUIRED_3A;
            SYNC_ACQUIRED_4:  state_d = cgbad_s ? LOSS_OF_SYNC : SYNC_ACQUIRED_4A;
            SYNC_ACQUIRED_4A: state_d = cgbad_s ? LOSS_OF_SYNC :
                                        (good_cgs_q == 2'd3) ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_4A;
            default:          state_d = LOSS_OF_SYNC;
        endcase
        if (sd_change_s && !mr_loopback) begin
            state_d = LOSS_OF_SYNC;
        end else begin
            state_d = state_d;
        end
    end

    // Moore actions of the state being entered.
    always_comb begin
        rx_even_d  = !rx_even_q;
        status_d   = status_q;
        good_cgs_d = good_cgs_q;
        case (state_d)
            COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3: rx_even_d = 1'b1;
            default:                                        rx_even_d = !rx_even_q;
        endcase
        if (state_d == LOSS_OF_SYNC) begin
            status_d = 1'b0;
        end else if (is_sync_acquired(state_d)) begin
            status_d = 1'b1;
        end else begin
            status_d = status_q;
        end
        case (state_d)
            SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4:
                good_cgs_d = 2'd0;
            SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A:
                good_cgs_d = (state_q == state_d) ? sat_inc2(good_cgs_q) : 2'd1;
            default:
                good_cgs_d = good_cgs_q;
        endcase
    end

    // State, counter, history and output registers.
    always_ff @(posedge clk or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state_q       <= LOSS_OF_SYNC;
            sudi_q        <= 10'd0;
            status_q      <= 1'b0;
            rx_even_q     <= 1'b0;
            good_cgs_q    <= 2'd0;
            sd_prev_q     <= 1'b0;
            sd_hist_vld_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sudi_q        <= sudi_d;
            status_q      <= status_d;
            rx_even_q     <= rx_even_d;
            good_cgs_q    <= good_cgs_d;
            sd_prev_q     <= sd_prev_d;
            sd_hist_vld_q <= sd_hist_vld_d;
        end
    end

    assign SUDI             = sudi_q;
    assign code_sync_status = status_q;
    assign rx_even          = rx_even_q;

endmodule

// File: tb/tb_pcs_synchronization.sv
// Scoreboard bench for pcs_synchronization: directed code-group vectors with hand-derived responses.
module tb_pcs_synchronization;
    import pcs_synchronization_pkg::*;

    logic       clk;
    logic       mr_main_reset;
    logic       mr_loopback;
    logic       signal_detect;
    logic [9:0] code_group;
    logic [9:0] SUDI;
    logic       code_sync_status;
    logic       rx_even;

    pcs_synchronization dut (
        .clk              (clk),
        .mr_main_reset    (mr_main_reset),
        .mr_loopback      (mr_loopback),
        .signal_detect    (signal_detect),
        .code_group       (code_group),
        .SUDI             (SUDI),
        .code_sync_status (code_sync_status),
        .rx_even          (rx_even)
    );

    typedef struct packed {
        logic [7:0] step;
        logic [9:0] cg;
        logic       st;
        logic       ev;
        logic [3:0] s;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;

    localparam logic [9:0] KN   = 10'b0011111010;
    localparam logic [9:0] KP   = 10'b1100000101;
    localparam logic [9:0] DD   = 10'b0110110101;
    localparam logic [9:0] D00  = 10'b1001110100;
    localparam logic [9:0] BAD  = 10'b0000000000;
    localparam logic [9:0] BAD4 = 10'b1001111111;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [9:0] got, input logic [9:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h exp=%h", name, idx, got, exp);
        end
    endtask

    task automatic send(input logic [9:0] cg, input logic sd, input logic lb,
                        input logic st, input logic ev, input sync_state_e s);
        exp_t e;
        @(negedge clk);
        step++;
        code_group    = cg;
        signal_detect = sd;
        mr_loopback   = lb;
        e.step = step[7:0];
        e.cg   = cg;
        e.st   = st;
        e.ev   = ev;
        e.s    = s;
        exp_q.push_back(e);
    endtask

    // Monitor: one response per clock, compared against the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("sudi",    int'(mon_e.step), SUDI, mon_e.cg);
            check("status",  int'(mon_e.step), {9'd0, code_sync_status}, {9'd0, mon_e.st});
            check("rx_even", int'(mon_e.step), {9'd0, rx_even}, {9'd0, mon_e.ev});
            check("state",   int'(mon_e.step), {6'd0, dut.state_q}, {6'd0, mon_e.s});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        mr_main_reset = 1'b0;
        mr_loopback   = 1'b0;
        signal_detect = 1'b1;
        code_group    = 10'd0;
        repeat (3) @(negedge clk);
        check("rst_sudi",    0, SUDI, 10'd0);
        check("rst_status",  0, {9'd0, code_sync_status}, 10'd0);
        check("rst_rx_even", 0, {9'd0, rx_even}, 10'd0);
        check("rst_state",   0, {6'd0, dut.state_q}, {6'd0, LOSS_OF_SYNC});
        mr_main_reset = 1'b1;

        // acquire: K28.5 / D16.2 three times
        send(KN,  1'b1, 1'b0, 1'b0, 1'b1, COMMA_DETECT_1);
        send(DD,  1'b1, 1'b0, 1'b0, 1'b0, ACQUIRE_SYNC_1);
        send(KN,  1'b1, 1'b0, 1'b0, 1'b1, COMMA_DETECT_2);
        send(DD,  1'b1, 1'b0, 1'b0, 1'b0, ACQUIRE_SYNC_2);
        send(KN,  1'b1, 1'b0, 1'b0, 1'b1, COMMA_DETECT_3);
        send(DD,  1'b1, 1'b0, 1'b1, 1'b0, SYNC_ACQUIRED_1);
        send(KN,  1'b1, 1'b0, 1'b1, 1'b1, SYNC_ACQUIRED_1);
        send(DD,  1'b1, 1'b0, 1'b1, 1'b0, SYNC_ACQUIRED_1);
        // one bad group, four good groups back to SYNC_ACQUIRED_1
        send(BAD, 1'b1, 1'b0, 1'b1, 1'b1, SYNC_ACQUIRED_2);
        send(DD,  1'b1, 1'b0, 1'b1, 1'b0, SYNC_ACQUIRED_2A);
        send(D00, 1'b1, 1'b0, 1'b1, 1'b1, SYNC_ACQUIRED_2A);
        send(DD,  1'b1, 1'b0, 1'b1, 1'b0, SYNC_ACQUIRED_2A);
        send(DD,  1'b1, 1'b0, 1'b1, 1'b1, SYNC_ACQUIRED_1);
        // comma in odd position counts as bad
        send(KN,  1'b1, 1'b0, 1'b1, 1'b0, SYNC_ACQUIRED_2);
        send(DD,  1'b1, 1'b0, 1'b1, 1'b1, SYNC_ACQUIRED_2A);
        send(DD,  1'b1, 1'b0, 1'b1, 1'b0, SYNC_ACQUIRED_2A);
        send(DD,  1'b1, 1'b0, 1'b1, 1'b1, SYNC_ACQUIRED_2A);
        send(DD,  1'b1, 1'b0, 1'b1, 1'b0, SYNC_ACQUIRED_1);
        // four bad groups with short good runs between them
        send(BAD, 1'b1, 1'b0, 1'b1, 1'b1, SYNC_ACQUIRED_2);
        send(DD,  1'b1, 1'b0, 1'b1, 1'b0, SYNC_ACQUIRED_2A);
        send(BAD, 1'b1, 1'b0, 1'b1, 1'b1, SYNC_ACQUIRED_3);
        send(DD,  1'b1, 1'b0, 1'b1, 1'b0, SYNC_ACQUIRED_3A);
        send(DD,  1'b1, 1'b0, 1'b1, 1'b1, SYNC_ACQUIRED_3A);
        send(BAD4,1'b1, 1'b0, 1'b1, 1'b0, SYNC_ACQUIRED_4);
        send(DD,  1'b1, 1'b0, 1'b1, 1'b1, SYNC_ACQUIRED_4A);
        send(BAD, 1'b1, 1'b0, 1'b0, 1'b0, LOSS_OF_SYNC);
        send(DD,  1'b1, 1'b0, 1'b0, 1'b1, LOSS_OF_SYNC);
        // K group in COMMA_DETECT_1 drops back
        send(KN,  1'b1, 1'b0, 1'b0, 1'b1, COMMA_DETECT_1);
        send(KN,  1'b1, 1'b0, 1'b0, 1'b0, LOSS_OF_SYNC);
        send(KN,  1'b1, 1'b0, 1'b0, 1'b1, COMMA_DETECT_1);
        send(DD,  1'b1, 1'b0, 1'b0, 1'b0, ACQUIRE_SYNC_1);
        send(KN,  1'b1, 1'b0, 1'b0, 1'b1, COMMA_DETECT_2);
        send(DD,  1'b1, 1'b0, 1'b0, 1'b0, ACQUIRE_SYNC_2);
        send(KN,  1'b1, 1'b0, 1'b0, 1'b1, COMMA_DETECT_3);
        send(DD,  1'b1, 1'b0, 1'b1, 1'b0, SYNC_ACQUIRED_1);
        send(DD,  1'b1, 1'b0, 1'b1, 1'b1, SYNC_ACQUIRED_1);
        // signal_detect toggles without loopback: sync lost, change beats the comma
        send(DD,  1'b0, 1'b0, 1'b0, 1'b0, LOSS_OF_SYNC);
        send(DD,  1'b0, 1'b0, 1'b0, 1'b1, LOSS_OF_SYNC);
        send(KN,  1'b1, 1'b0, 1'b0, 1'b0, LOSS_OF_SYNC);
        send(KN,  1'b1, 1'b0, 1'b0, 1'b1, COMMA_DETECT_1);
        send(DD,  1'b1, 1'b0, 1'b0, 1'b0, ACQUIRE_SYNC_1);
        send(KN,  1'b1, 1'b0, 1'b0, 1'b1, COMMA_DETECT_2);
        send(DD,  1'b1, 1'b0, 1'b0, 1'b0, ACQUIRE_SYNC_2);
        send(KN,  1'b1, 1'b0, 1'b0, 1'b1, COMMA_DETECT_3);
        send(DD,  1'b1, 1'b0, 1'b1, 1'b0, SYNC_ACQUIRED_1);
        // loopback: signal_detect toggles are ignored
        send(DD,  1'b0, 1'b1, 1'b1, 1'b1, SYNC_ACQUIRED_1);
        send(DD,  1'b1, 1'b1, 1'b1, 1'b0, SYNC_ACQUIRED_1);
        send(KN,  1'b1, 1'b1, 1'b1, 1'b1, SYNC_ACQUIRED_1);
        // positive-disparity K28.5 in odd position
        send(KP,  1'b1, 1'b0, 1'b1, 1'b0, SYNC_ACQUIRED_2);
        send(DD,  1'b1, 1'b0, 1'b1, 1'b1, SYNC_ACQUIRED_2A);

        // asynchronous reset while synced
        @(posedge clk);
        #2;
        mr_main_reset = 1'b0;
        #1;
        check("arst_sudi",    99, SUDI, 10'd0);
        check("arst_status",  99, {9'd0, code_sync_status}, 10'd0);
        check("arst_rx_even", 99, {9'd0, rx_even}, 10'd0);
        check("arst_state",   99, {6'd0, dut.state_q}, {6'd0, LOSS_OF_SYNC});
        check("queue_drain",  99, exp_q.size() > 0 ? 10'd1 : 10'd0, 10'd0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
